// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational 1-bit full adder built from two half adders and an OR gate.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1_s;
  logic c1_s;
  logic c2_s;

  half_adder u_ha0 (.a(a),    .b(b),  .s(s1_s), .c(c1_s));
  half_adder u_ha1 (.a(s1_s), .b(ci), .s(s),    .c(c2_s));

  assign co = c1_s | c2_s;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder; two of these form the shared full-adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: operands in over valid/ready, LSB-first through one
// shared full-adder cell, result out over valid/ready.
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  // Holds the WIDTH-1 sum bits produced so far; the last bit comes straight from the cell.
  logic [WIDTH-2:0] sum_sh_r;
  logic             carry_r;
  logic             fa_s_s;
  logic             fa_co_s;
  logic [WIDTH-1:0] sum_next_s;

  full_adder_cell u_fa (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .ci (carry_r),
    .s  (fa_s_s),
    .co (fa_co_s)
  );

  assign sum_next_s = {fa_s_s, sum_sh_r};

  // Sequencer FSM with datapath shift registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      a_sh_r    <= {WIDTH{1'b0}};
      b_sh_r    <= {WIDTH{1'b0}};
      sum_sh_r  <= {(WIDTH-1){1'b0}};
      carry_r   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= {WIDTH{1'b0}};
      cout      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh_r   <= a_in;
            b_sh_r   <= b_in;
            carry_r  <= cin;
            cnt_r    <= {CW{1'b0}};
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_r  <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          sum_sh_r <= sum_next_s[WIDTH-1:1];
          carry_r  <= fa_co_s;
          cnt_r    <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            sum       <= sum_next_s;
            cout      <= fa_co_s;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_r   <= DONE;
          end else begin
            state_r <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          // Unused encoding: drop any partial operation and return to a safe idle.
          state_r   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed and randomized checks for serial_add_sequencer at WIDTH=8.
module tb_serial_add_sequencer;

  localparam int W = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
    int         stall;
    bit         early;
    bit         inj;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t tbl[12];

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int n;
    @(negedge clk);
    a_in      = v.a;
    b_in      = v.b;
    cin       = v.ci;
    in_valid  = 1'b1;
    out_ready = v.early;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_in     = 8'($urandom);
    b_in     = 8'($urandom);
    cin      = 1'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (v.inj && n == 2) begin
        in_valid = 1'b1;
        a_in     = 8'h11;
      end
      if (v.inj && n == 4) in_valid = 1'b0;
      if (n == 1) begin
        chk("busy_in_run", 32'(busy), 32'd1);
        chk("in_ready_in_run", 32'(in_ready), 32'd0);
      end
    end while (!out_valid && n < 40);
    chk("latency", 32'(n), 32'(W + 1));
    chk("sum", 32'(sum), 32'(v.s));
    chk("cout", 32'(cout), 32'(v.co));
    chk("busy_in_done", 32'(busy), 32'd0);
    if (!v.early) begin
      for (int k = 0; k < v.stall; k++) begin
        @(negedge clk);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_sum", 32'({cout, sum}), 32'({v.co, v.s}));
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_sum_hold", 32'({cout, sum}), 32'({v.co, v.s}));
  endtask

  initial begin
    vec_t       rv;
    logic [8:0] ref_r;

    tbl[0]  = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0, 1'b0, 1'b0};
    tbl[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0};
    tbl[2]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0, 1'b1, 1'b0};
    tbl[3]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0};
    tbl[4]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0};
    tbl[5]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 5, 1'b0, 1'b0};
    tbl[6]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 0, 1'b0, 1'b0};
    tbl[7]  = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 0, 1'b1, 1'b0};
    tbl[8]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1, 1'b0, 1'b0};
    tbl[9]  = '{8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 0, 1'b0, 1'b0};
    tbl[10] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, 1'b0, 1'b1};
    tbl[11] = '{8'h01, 8'h80, 1'b1, 8'h82, 1'b0, 3, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a_in      = 8'h00;
    b_in      = 8'h00;
    cin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sum_cout", 32'({cout, sum}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_op(tbl[i]);

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    a_in     = 8'h5A;
    b_in     = 8'h3C;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_sum", 32'({cout, sum}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(tbl[10]);

    for (int i = 0; i < 150; i++) begin
      rv.a     = 8'($urandom);
      rv.b     = 8'($urandom);
      rv.ci    = 1'($urandom);
      ref_r    = {1'b0, rv.a} + {1'b0, rv.b} + {8'h00, rv.ci};
      rv.s     = ref_r[7:0];
      rv.co    = ref_r[8];
      rv.stall = $urandom_range(0, 3);
      rv.early = 1'($urandom_range(0, 1));
      rv.inj   = 1'b0;
      run_op(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
